// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel programmable clock divider with glitch-free reconfiguration
// Optional CLKDIV_PHASE_EN: cfg_phase sets the start count after enable and is range-checked.
module clk_div_bank #(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 8,
  parameter int DEFAULT_DIV  = 6,
  parameter int LOCK_PERIODS = 2,
  localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] lock
);

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_HIGH = DIV_W'(DEFAULT_DIV / 2);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_PERIODS);

  logic [NUM_CH-1:0]     pending;
  logic [(1<<CHW)-1:0]   pend_ext;
  logic                  xfer;
  logic                  bad;
  logic                  xfer_ok;
  logic                  err_r;

  // Unused channel codes read as ready so a stray request never stalls the master.
  always_comb begin
    pend_ext = '0;
    pend_ext[NUM_CH-1:0] = pending;
  end

  assign cfg_ready = ~pend_ext[cfg_ch];
  assign xfer      = cfg_valid && cfg_ready;
  assign xfer_ok   = xfer && !bad;
  assign cfg_err   = err_r;

`ifdef CLKDIV_PHASE_EN
  always_comb begin
    bad = (cfg_div < TWO) || (cfg_high > cfg_div) || (cfg_phase >= cfg_div);
  end
`else
  logic unused_phase;
  assign unused_phase = ^cfg_phase;

  always_comb begin
    bad = (cfg_div < TWO) || (cfg_high > cfg_div);
  end
`endif

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= xfer && bad;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] act_high;
    logic [DIV_W-1:0] sh_div;
    logic [DIV_W-1:0] sh_high;
    logic [DIV_W-1:0] new_high;
    logic [DIV_W-1:0] start_cnt;
    logic [DIV_W-1:0] next_cnt;
    logic [3:0]       lcnt;
    logic             run;
    logic             pend;
    logic             clk_r;
    logic             pulse_r;
    logic             lock_r;
    logic             sel;
    logic             term;
    logic             apply;

    assign sel      = xfer_ok && (cfg_ch == CHW'(g));
    assign term     = (cnt == act_div - ONE);
    // Shadow takes effect only at a period boundary, or at once when the channel is (going) off.
    assign apply    = pend && (!run || !enable[g] || term);
    assign new_high = apply ? sh_high : act_high;
    assign next_cnt = term ? '0 : cnt + ONE;

`ifdef CLKDIV_PHASE_EN
    logic [DIV_W-1:0] act_phase;
    logic [DIV_W-1:0] sh_phase;

    assign start_cnt = apply ? sh_phase : act_phase;

    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        act_phase <= '0;
        sh_phase  <= '0;
      end else if (sel) begin
        sh_phase  <= cfg_phase;
      end else if (apply) begin
        act_phase <= sh_phase;
      end
    end
`else
    assign start_cnt = '0;
`endif

    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        run     <= 1'b0;
        clk_r   <= 1'b0;
        pulse_r <= 1'b0;
      end else if (!enable[g]) begin
        cnt     <= '0;
        run     <= 1'b0;
        clk_r   <= 1'b0;
        pulse_r <= 1'b0;
      end else if (!run) begin
        cnt     <= start_cnt;
        run     <= 1'b1;
        clk_r   <= (start_cnt < new_high);
        pulse_r <= (start_cnt == '0);
      end else begin
        cnt     <= next_cnt;
        clk_r   <= (next_cnt < new_high);
        pulse_r <= (next_cnt == '0);
      end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        pend     <= 1'b0;
        act_div  <= DEF_DIV;
        act_high <= DEF_HIGH;
        sh_div   <= DEF_DIV;
        sh_high  <= DEF_HIGH;
      end else if (sel) begin
        pend     <= 1'b1;
        sh_div   <= cfg_div;
        sh_high  <= cfg_high;
      end else if (apply) begin
        pend     <= 1'b0;
        act_div  <= sh_div;
        act_high <= sh_high;
      end
    end

    // Pulses are not counted while a shadow waits: the old waveform is about to be replaced.
    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        lcnt   <= '0;
        lock_r <= 1'b0;
      end else if (!enable[g] || !run || sel || apply) begin
        lcnt   <= '0;
        lock_r <= 1'b0;
      end else if (!pend && pulse_r && (lcnt != LOCK_N)) begin
        lcnt   <= lcnt + 4'd1;
        lock_r <= ((lcnt + 4'd1) == LOCK_N);
      end
    end

    assign clkout[g]  = clk_r;
    assign pulse[g]   = pulse_r;
    assign lock[g]    = lock_r;
    assign pending[g] = pend;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - randomized scoreboard bench for clk_div_bank against a period-position model
module tb_clk_div_bank;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int LP     = 2;
  localparam int CHW    = 2;

  logic              clkin     = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NUM_CH-1:0] enable    = '0;
  logic              cfg_valid = 1'b0;
  logic [CHW-1:0]    cfg_ch    = '0;
  logic [DIV_W-1:0]  cfg_div   = '0;
  logic [DIV_W-1:0]  cfg_high  = '0;
  logic [DIV_W-1:0]  cfg_phase = '0;
  logic              cfg_ready;
  logic              cfg_err;
  logic [NUM_CH-1:0] clkout;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] lock;

  clk_div_bank #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(6), .LOCK_PERIODS(LP)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .clkout(clkout), .pulse(pulse), .lock(lock)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [NUM_CH-1:0] ck;
    logic [NUM_CH-1:0] pl;
    logic [NUM_CH-1:0] lk;
    logic              err;
    logic              rdy;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: each channel is a position within its current period plus the active/waiting configs.
  int m_run[NUM_CH], m_p[NUM_CH], m_div[NUM_CH], m_high[NUM_CH], m_ph[NUM_CH];
  int m_pend[NUM_CH], s_div[NUM_CH], s_high[NUM_CH], s_ph[NUM_CH], m_lcnt[NUM_CH];
  bit m_xfer, m_err;

  logic [NUM_CH-1:0] n_en = '0;
  logic              n_valid = 1'b0;
  logic [CHW-1:0]    n_ch = '0;
  logic [DIV_W-1:0]  n_div = '0, n_high = '0, n_phase = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_p[c] = 0; m_div[c] = 6; m_high[c] = 3; m_ph[c] = 0;
      m_pend[c] = 0; s_div[c] = 6; s_high[c] = 3; s_ph[c] = 0; m_lcnt[c] = 0;
    end
    m_xfer = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    int d, h, ph, ch, np;
    bit bad, ok, pulse_now, app;
    d = int'(cfg_div); h = int'(cfg_high); ph = int'(cfg_phase); ch = int'(cfg_ch);
    bad = (d < 2) || (h > d);
`ifdef CLKDIV_PHASE_EN
    bad = bad || (ph >= d);
`endif
    m_xfer = cfg_valid && (m_pend[ch] == 0);
    m_err  = m_xfer && bad;
    ok     = m_xfer && !bad;
    for (int c = 0; c < NUM_CH; c++) begin
      pulse_now = (m_run[c] != 0) && (m_p[c] == 0);
      app = (m_pend[c] != 0) && ((m_run[c] == 0) || !enable[c] || (m_p[c] == m_div[c] - 1));
      np = (m_p[c] + 1) % m_div[c];
      if (app) begin
        m_div[c] = s_div[c]; m_high[c] = s_high[c]; m_ph[c] = s_ph[c]; m_pend[c] = 0;
      end
      if (!enable[c]) begin
        m_run[c] = 0; m_p[c] = 0; m_lcnt[c] = 0;
      end else if (m_run[c] == 0) begin
        m_run[c] = 1; m_lcnt[c] = 0;
`ifdef CLKDIV_PHASE_EN
        m_p[c] = m_ph[c];
`else
        m_p[c] = 0;
`endif
      end else begin
        m_p[c] = app ? 0 : np;
        if ((ok && ch == c) || app) m_lcnt[c] = 0;
        else if (m_pend[c] == 0 && pulse_now && m_lcnt[c] < LP) m_lcnt[c]++;
      end
      if (ok && ch == c) begin
        m_pend[c] = 1; s_div[c] = d; s_high[c] = h; s_ph[c] = ph;
      end
    end
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clkin);
    model_step();
    #1;
    if (m_xfer) n_valid = 1'b0;
    enable = n_en; cfg_valid = n_valid; cfg_ch = n_ch;
    cfg_div = n_div; cfg_high = n_high; cfg_phase = n_phase;
    for (int c = 0; c < NUM_CH; c++) begin
      e.ck[c] = (m_run[c] != 0) && (m_p[c] < m_high[c]);
      e.pl[c] = (m_run[c] != 0) && (m_p[c] == 0);
      e.lk[c] = (m_lcnt[c] >= LP);
    end
    e.err = m_err;
    e.rdy = (m_pend[int'(cfg_ch)] == 0);
    q.push_back(e);
  endtask

  task automatic send(input int ch, input int d, input int h, input int ph);
    n_valid = 1'b1; n_ch = CHW'(ch);
    n_div = DIV_W'(d); n_high = DIV_W'(h); n_phase = DIV_W'(ph);
    for (int i = 0; i < 400 && n_valid; i++) tick();
    if (n_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout ch %0d: request still outstanding, required accepted", ch);
      n_valid = 1'b0;
      tick();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_clkout"}, clkout, 0);
    chk({tag, "_pulse"}, pulse, 0);
    chk({tag, "_lock"}, lock, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clkin);
    #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    n_valid = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
  endtask

  always @(negedge clkin) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("clkout", clkout, e.ck);
      chk("pulse", pulse, e.pl);
      chk("lock", lock, e.lk);
      chk("cfg_err", cfg_err, e.err);
      chk("cfg_ready", cfg_ready, e.rdy);
    end
  end

  initial begin
    int k;
    model_reset();
    repeat (2) @(negedge clkin);
    check_zero("reset");
    rst_n = 1'b1;

    n_en = 4'b0001; tick();
    repeat (30) tick();
    n_en = 4'b0011; repeat (9) tick();
    send(1, 10, 3, 0); repeat (40) tick();
    send(1, 1, 0, 0);  repeat (3) tick();
    send(1, 6, 7, 0);  repeat (10) tick();
    n_en = 4'b0111; repeat (5) tick();
    send(2, 8, 4, 0);
    send(2, 5, 2, 0);
    repeat (30) tick();
`ifdef CLKDIV_PHASE_EN
    n_en[3:2] = 2'b00; tick();
    send(2, 8, 4, 0);
    send(3, 8, 4, 4);
    repeat (3) tick();
    n_en[3:2] = 2'b11; repeat (40) tick();
`endif
    send(0, 4, 1, 0);
    n_en[0] = 1'b0; repeat (5) tick();
    n_en[0] = 1'b1; repeat (20) tick();
    do_reset();
    n_en = 4'b1111; repeat (20) tick();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 39) == 0) begin
        k = $urandom_range(0, NUM_CH - 1);
        n_en[k] = ~n_en[k];
      end
      if (!n_valid && $urandom_range(0, 5) == 0) begin
        n_valid = 1'b1;
        n_ch    = CHW'($urandom_range(0, NUM_CH - 1));
        n_div   = DIV_W'($urandom_range(0, 12));
        n_high  = DIV_W'($urandom_range(0, 13));
        n_phase = DIV_W'($urandom_range(0, 12));
      end
      tick();
    end

    n_valid = 1'b0;
    repeat (5) tick();
    @(negedge clkin);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock divider.
- Runs entirely in the PLL output domain (`clkin`).
- Generates `NUM_CH` independent divided waveforms plus one-cycle period strobes.
- Each channel's divide ratio, duty (high count) and phase offset are reprogrammable at run time, glitch-free, with a per-channel lock indicator; this generalises the fixed single CLKOUTD divider into a configurable bank for LED/peripheral timing.

Parameters:
- `NUM_CH`, 4, number of divider channels (1..16).
- `DIV_W`, 8, width of the divide/high/phase fields.
- `DEFAULT_DIV`, 6, divide ratio loaded at reset (>=2).
- `LOCK_PERIODS`, 2, full output periods after start/apply before `lock` asserts (1..15).

Ports:
- `clkin`, in, 1, clock (PLL output).
- `rst_n`, in, 1, asynchronous active-low reset.
- `enable`, in, `NUM_CH`, per-channel run enable.
- `cfg_valid`, in, 1, config request.
- `cfg_ready`, out, 1, config can be accepted for `cfg_ch`.
- `cfg_ch`, in, `CHW`=max(1,clog2(`NUM_CH`)), target channel.
- `cfg_div`, in, `DIV_W`, divide ratio N (period = N `clkin` cycles).
- `cfg_high`, in, `DIV_W`, cycles high per period.
- `cfg_phase`, in, `DIV_W`, start count offset.
- `cfg_err`, out, 1, one-cycle pulse: last accepted config rejected.
- `clkout`, out, `NUM_CH`, divided waveforms (registered).
- `pulse`, out, `NUM_CH`, one-cycle strobe at count 0 (registered).
- `lock`, out, `NUM_CH`, channel stable.

Behaviour:
- Reset (async assert, sync release):
  - `clkout`=0, `pulse`=0, `lock`=0, `cfg_err`=0, `cfg_ready`=1.
  - Active config of every channel: div=`DEFAULT_DIV`, high=`DEFAULT_DIV`/2, phase=0. No pending configs; counters 0.
- Per-channel states:
  - OFF (`enable`=0): counter held 0, `clkout`/`pulse`/`lock`=0.
  - RUN: counter increments mod div.
  - RUN_PEND: RUN with a shadow config waiting.
- Enable sampled 1 at edge k: in cycle k+1, cnt=phase, `clkout`=(cnt<high), `pulse`=(cnt==0). Thereafter cnt advances 1 per cycle and wraps at div-1 -> 0.
- `clkout` and `pulse` are flops aligned with cnt: `clkout` high exactly while cnt<high; `pulse` high exactly while cnt==0.
- Handshake:
  - Transfer when `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = ~pending[`cfg_ch`] (combinational on `cfg_ch`).
  - Inputs only sampled on transfer.
- Validation on transfer: rejected if div<2, high>div, or phase>=div.
  - Rejected: `cfg_err` pulses the next cycle; no state change; `lock` unaffected.
- Valid transfer:
  - Shadow loaded, pending set.
  - `lock` of that channel deasserts the next cycle.
- Apply:
  - RUN_PEND applies the shadow on the edge where cnt==div_old-1.
  - The new period starts with cnt=0 (phase ignored on reload to avoid runt pulses); pending clears the same edge.
  - If the transfer coincides with the terminal-count cycle, the apply happens at the following terminal count, not that cycle.
- Lock: counts `pulse` events after enable rise or apply. Asserts in the cycle after the `LOCK_PERIODS`-th pulse (saturating counter); cleared by OFF, valid transfer, or reset.
- Disable:
  - `enable` falling -> OFF next cycle (`clkout` 0 immediately; a truncated high phase is accepted).
  - Any pending shadow applies in that same cycle, so a disabled channel never holds pending.
  - A transfer to an OFF channel applies next cycle.
- Simultaneous disable and transfer on the same channel: stored, then applied the cycle after (channel OFF).
- Channels fully independent; no cross-channel alignment except identical enable timing.
- Reset mid-operation: all state to reset values immediately (async); no output glitch beyond going to 0.

Optional Feature:
- `CLKDIV_PHASE_EN` defined: `cfg_phase` is honoured at enable start and validated (phase>=div -> reject).
- Undefined: `cfg_phase` ignored, no phase registers; counter always starts at 0; the phase check is removed. The port remains present.

Test Plan:
- Reset release, `enable`[0]=1 at default: `clkout`[0] period 6, high 3 cycles; `pulse`[0] every 6 cycles starting first cycle; `lock`[0]=1 the cycle after the 2nd pulse.
- Ch1 running div 6: transfer div=10 high=3 mid-period -> current 6-cycle period completes, then periods of 10 with 3 high. `lock`[1]=0 from next cycle until after 2 new pulses.
- Transfer div=1 (or high=7 with div=6) -> `cfg_err` 1-cycle pulse next cycle, waveform and `lock` unchanged.
- Two back-to-back transfers to ch2 -> `cfg_ready` low after first until apply at terminal count. Second held by master, accepted after, applied one period later.
- `CLKDIV_PHASE_EN` defined: ch2 and ch3 div=8 high=4, phase 0 and 4, enables rise same edge -> `pulse`[3] leads `pulse`[2] by 4 cycles and stays fixed.
- Pending config on ch0 then `enable`[0]=0 -> `clkout` 0 next cycle, pending applied (`cfg_ready` high). Re-enable -> new div observed. Assert `rst_n`=0 mid-period -> all outputs 0 with no clock edge needed.
